// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, schedule FSM states and sigma rotate amounts.
package sha256_pkg;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/sha256_sched_window.sv
// 16x32 circular window of schedule words: one write port, four combinational read taps.
module sha256_sched_window
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  word_t      wdata,
  input  logic [3:0] raddr_a,
  input  logic [3:0] raddr_b,
  input  logic [3:0] raddr_c,
  input  logic [3:0] raddr_d,
  output word_t      rdata_a,
  output word_t      rdata_b,
  output word_t      rdata_c,
  output word_t      rdata_d
);
  word_t mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];
  assign rdata_d = mem[raddr_d];
endmodule

// File: rtl/sha256_sigma.sv
// Small-sigma functions of the message schedule, shared with the round engine.
module sha256_sigma0
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
endmodule

module sha256_sigma1
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
endmodule

// File: rtl/sha256_msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads W0..W15, expands W16..W(ROUNDS-1),
// and streams every word through a single-register valid/ready output slot.
module sha256_msg_schedule_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  output logic        BUSY,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_WORD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_WORD,
  output logic [5:0]  OUT_IDX,
  output logic        DONE
);
  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t     state, state_nx;
  logic [5:0] t;
  logic       free, load_acc, exp_go, win_we;
  word_t      win_wdata, w_new;
  word_t      tap_m2, tap_m7, tap_m15, tap_m16, sig0, sig1;

  // Taps relative to t: W[t-2], W[t-7], W[t-15], W[t-16] (mod-16 wrap of the window).
  sha256_sched_window u_window (
    .clk     (CLK),
    .we      (win_we),
    .waddr   (t[3:0]),
    .wdata   (win_wdata),
    .raddr_a (t[3:0] + 4'd14),
    .raddr_b (t[3:0] + 4'd9),
    .raddr_c (t[3:0] + 4'd1),
    .raddr_d (t[3:0]),
    .rdata_a (tap_m2),
    .rdata_b (tap_m7),
    .rdata_c (tap_m15),
    .rdata_d (tap_m16)
  );

  sha256_sigma0 u_sigma0 (.x(tap_m15), .y(sig0));
  sha256_sigma1 u_sigma1 (.x(tap_m2),  .y(sig1));

  assign w_new = sig1 + tap_m7 + sig0 + tap_m16;

  always_comb begin
    state_nx  = state;
    free      = !OUT_VALID || OUT_READY;
    IN_READY  = (state == LOAD) && free;
    load_acc  = IN_READY && IN_VALID;
    exp_go    = (state == EXPAND) && free;
    win_we    = load_acc || exp_go;
    win_wdata = load_acc ? IN_WORD : w_new;
    BUSY      = (state != IDLE);
    unique case (state)
      IDLE:    if (START) state_nx = LOAD;
      LOAD:    if (load_acc && t == 6'd15) state_nx = EXPAND;
      EXPAND:  if (exp_go && t == LAST_T) state_nx = DRAIN;
      DRAIN:   if (OUT_VALID && OUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      t         <= '0;
      OUT_VALID <= 1'b0;
      OUT_WORD  <= '0;
      OUT_IDX   <= '0;
      DONE      <= 1'b0;
    end else begin
      DONE <= (state == DRAIN) && OUT_VALID && OUT_READY;
      if (state == IDLE && START) t <= '0;
      // Refill takes priority over the drain so a same-cycle take-and-load keeps OUT_VALID high.
      if (win_we) begin
        OUT_WORD  <= win_wdata;
        OUT_IDX   <= t;
        OUT_VALID <= 1'b1;
        t         <= t + 6'd1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// Self-checking bench for sha256_msg_schedule_ctrl against an arithmetic schedule model.
module tb_sha256_msg_schedule_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        BUSY;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_WORD = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_WORD;
  logic [5:0]  OUT_IDX;
  logic        DONE;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] msg [16];
  logic [31:0] ref_w [64];
  logic [31:0] got [64];

  sha256_msg_schedule_ctrl #(.ROUNDS(64)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BUSY      (BUSY),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_WORD   (IN_WORD),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_WORD  (OUT_WORD),
    .OUT_IDX   (OUT_IDX),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) ref_w[i] = msg[i];
      else ref_w[i] = ss1(ref_w[i-2]) + ref_w[i-7] + ss0(ref_w[i-15]) + ref_w[i-16];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  // Runs one block from IDLE; returns cycles from the first LOAD cycle to the DONE cycle.
  task automatic run_block(input int gap_pct, input int stall_pct, input bit hold_start,
                           input int abort_idx, input bit noise, output int cycles);
    int in_idx = 0;
    int out_idx = 0;
    bit prev_stall = 0;
    bit xfer_last = 0;
    bit finished = 0;
    bit xl;
    logic [31:0] held_w = '0;
    logic [5:0]  held_i = '0;
    cycles = 0;
    build_ref();
    START = 1'b1;
    @(negedge CLK);
    START = hold_start;
    #1 chk("busy_after_start", 32'(BUSY), 32'd1);
    while (!finished && cycles < 3000) begin
      if (out_idx == abort_idx) begin
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        #1;
        chk("abort_out_valid", 32'(OUT_VALID), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_in_ready", 32'(IN_READY), 32'd0);
        RST_N = 1'b1;
        START = 1'b0;
        return;
      end
      IN_VALID  = (in_idx < 16) ? ($urandom_range(99) >= 32'(gap_pct)) : noise;
      IN_WORD   = (in_idx < 16) ? msg[in_idx] : $urandom;
      OUT_READY = ($urandom_range(99) >= 32'(stall_pct));
      #1;
      chk("done_pulse", 32'(DONE), 32'(xfer_last));
      if (xfer_last) begin
        finished = 1;
      end else begin
        xl = 0;
        if (prev_stall) begin
          chk("stall_valid", 32'(OUT_VALID), 32'd1);
          chk("stall_word", OUT_WORD, held_w);
          chk("stall_idx", 32'(OUT_IDX), 32'(held_i));
        end
        chk("in_ready", 32'(IN_READY), 32'((in_idx < 16) && (!OUT_VALID || OUT_READY)));
        if (IN_VALID && IN_READY) in_idx++;
        if (OUT_VALID && OUT_READY) begin
          chk("out_idx", 32'(OUT_IDX), 32'(out_idx));
          chk("out_word", OUT_WORD, ref_w[out_idx]);
          got[out_idx] = OUT_WORD;
          if (out_idx == 63) begin
            xl = 1;
            START = 1'b0;
          end
          out_idx++;
        end
        prev_stall = OUT_VALID && !OUT_READY;
        held_w = OUT_WORD;
        held_i = OUT_IDX;
        xfer_last = xl;
        cycles++;
        @(negedge CLK);
      end
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    IN_VALID = 1'b0;
    START = 1'b0;
    chk("transfer_count", 32'(out_idx), 32'd64);
    @(negedge CLK);
    #1;
    chk("done_single", 32'(DONE), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("idle_out_valid", 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    int cyc;

    // Reset state
    RST_N = 1'b0;
    START = 1'b1;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_word", OUT_WORD, 32'd0);
    chk("rst_out_idx", 32'(OUT_IDX), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    START = 1'b0;
    IN_VALID = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);

    // 1. "abc" block at full throughput
    set_abc();
    run_block(0, 0, 1'b0, 99, 1'b0, cyc);
    chk("abc_cycles", 32'(cyc), 32'd65);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w18", got[18], 32'h7DA86405);
    chk("abc_w63", got[63], 32'h12B1EDEB);

    // 2. All-zero block
    for (int i = 0; i < 16; i++) msg[i] = '0;
    run_block(0, 0, 1'b0, 99, 1'b0, cyc);

    // 3. Back-pressure
    set_abc();
    run_block(0, 50, 1'b0, 99, 1'b0, cyc);

    // 4. Reset mid-block, then a fresh block
    set_abc();
    run_block(0, 30, 1'b0, 30, 1'b0, cyc);
    @(negedge CLK);
    run_block(0, 0, 1'b0, 99, 1'b0, cyc);
    chk("post_reset_cycles", 32'(cyc), 32'd65);

    // 5. START held throughout the block, then a second block after DONE
    run_block(0, 20, 1'b1, 99, 1'b1, cyc);
    run_block(0, 0, 1'b0, 99, 1'b0, cyc);
    chk("second_w63", got[63], 32'h12B1EDEB);

    // 6. IN_VALID gaps with noise during expansion
    run_block(60, 0, 1'b0, 99, 1'b1, cyc);

    // Random messages with gaps and stalls
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      run_block(30, 40, 1'b0, 99, 1'b1, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
